uart_tx_sched: RTL and testbench

//  Transmit scheduler in front of the PISO UART transmitter. Arbitrates NREQ byte sources

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_sched_rr_arbiter.sv | 39 +++
 rtl/uart_tx_sched.sv | 151 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, widths and parity helper for the UART transmit scheduler.
// Optional feature macro used by uart_tx_sched: UART_TX_TIMEOUT_EN.
package uart_pkg;

   localparam int UART_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_ACTIVE,
      WAIT_DONE,
      GAP
   } tx_sched_state_e;

   function automatic logic parity_f(
      input logic [UART_DATA_W-1:0] data,
      input logic                   odd
   );
      return odd ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first active request at or
// after ptr (wrapping); grant is all-zero when en is low.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int PW   = $clog2(NREQ)
)(
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [PW-1:0]   grant_idx
);

   localparam logic [PW:0] NR = (PW+1)'(NREQ);

   logic [PW:0] w_sum;
   logic        w_found;

   // Scan requesters starting at the pointer and take the first one asserted
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      w_sum     = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, ptr} + (PW+1)'(k);
         if (w_sum >= NR)
            w_sum = w_sum - NR;
         if (en && !w_found && req[w_sum[PW-1:0]]) begin
            w_found                = 1'b1;
            grant[w_sum[PW-1:0]]   = 1'b1;
            grant_idx              = w_sum[PW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler driving a PISO UART transmitter.
// Define UART_TX_TIMEOUT_EN to add the per-frame watchdog (timeout_err).
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NREQ           = 2,
   parameter int PARITY_ODD     = 0,
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 256
)(
   input  logic                        baud_clk,
   input  logic                        reset_n,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ*UART_DATA_W-1:0] req_data,
   output logic [NREQ-1:0]             req_ready,
   output logic [$clog2(NREQ)-1:0]     grant_id,
   output logic                        busy,
   output logic [UART_DATA_W-1:0]      piso_data_in,
   output logic                        piso_send,
   output logic                        piso_parity_bit,
   input  logic                        piso_active_flag,
   input  logic                        piso_done_flag,
   output logic                        timeout_err
);

   localparam int PW = $clog2(NREQ);
   localparam int GW = $clog2(GAP_CYCLES + 2);
   localparam logic [GW-1:0] GAP_LAST =
      GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic ODD = (PARITY_ODD != 0);
   localparam tx_sched_state_e POST_FRAME =
      (GAP_CYCLES == 0) ? IDLE : GAP;

   tx_sched_state_e        r_state;
   tx_sched_state_e        w_next;
   logic [PW-1:0]          r_ptr;
   logic [PW-1:0]          r_grant_id;
   logic [PW-1:0]          w_grant_idx;
   logic [NREQ-1:0]        w_grant;
   logic [UART_DATA_W-1:0] r_data;
   logic [UART_DATA_W-1:0] w_sel_data;
   logic                   r_parity;
   logic [GW-1:0]          r_gap_cnt;
   logic                   w_en;
   logic                   w_accept;
   logic                   w_waiting;
   logic                   w_timeout;

   assign w_en       = (r_state == IDLE) & reset_n;
   assign w_accept   = |w_grant;
   assign w_waiting  = (r_state == WAIT_ACTIVE) | (r_state == WAIT_DONE);
   assign w_sel_data = req_data[{w_grant_idx, 3'b000} +: UART_DATA_W];

   rr_arbiter #(
      .NREQ      (NREQ)
   ) u_arb (
      .req       (req_valid),
      .ptr       (r_ptr),
      .en        (w_en),
      .grant     (w_grant),
      .grant_idx (w_grant_idx)
   );

`ifdef UART_TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_wd_cnt;

   // Time spent waiting on the PISO; restarts with every accepted byte
   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n)
         r_wd_cnt <= '0;
      else if (w_accept)
         r_wd_cnt <= '0;
      else if (w_waiting)
         r_wd_cnt <= r_wd_cnt + 1'b1;
   end

   assign w_timeout = w_waiting & ~piso_done_flag &
                      (r_wd_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   assign req_ready       = w_grant;
   assign grant_id        = r_grant_id;
   assign piso_data_in    = r_data;
   assign piso_parity_bit = r_parity;
   assign timeout_err     = w_timeout;

   // State register
   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_next    = r_state;
      busy      = (r_state != IDLE);
      piso_send = (r_state == LAUNCH);
      unique case (r_state)
         IDLE:
            if (w_accept)
               w_next = LAUNCH;
         LAUNCH:
            w_next = WAIT_ACTIVE;
         WAIT_ACTIVE:
            if (piso_done_flag || w_timeout)
               w_next = POST_FRAME;
            else if (piso_active_flag)
               w_next = WAIT_DONE;
         WAIT_DONE:
            if (piso_done_flag || w_timeout)
               w_next = POST_FRAME;
         GAP:
            if (r_gap_cnt == GAP_LAST)
               w_next = IDLE;
         default:
            w_next = IDLE;
      endcase
   end

   // Holding register, parity, grant id and round-robin pointer
   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr      <= '0;
         r_grant_id <= '0;
         r_data     <= '0;
         r_parity   <= 1'b0;
      end else if (w_accept) begin
         r_data     <= w_sel_data;
         r_parity   <= parity_f(w_sel_data, ODD);
         r_grant_id <= w_grant_idx;
         r_ptr      <= (w_grant_idx == PW'(NREQ - 1)) ?
                       '0 : w_grant_idx + 1'b1;
      end
   end

   // Inter-frame gap counter, running only while in GAP
   always_ff @(posedge baud_clk or negedge reset_n) begin
      if (!reset_n)
         r_gap_cnt <= '0;
      else if (r_state != GAP)
         r_gap_cnt <= '0;
      else
         r_gap_cnt <= r_gap_cnt + 1'b1;
   end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench with a PISO model for uart_tx_sched.
// Define UART_TX_TIMEOUT_EN to also exercise the watchdog.
module tb_uart_tx_sched;

   localparam int NREQ = 2;
   localparam int GAP  = 2;
   localparam int TMO  = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
      logic       po;
      logic [0:0] id;
   } item_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req_valid = '0;
   logic [15:0] req_data = '0;
   logic        act = 1'b0;
   logic        done = 1'b0;

   logic [1:0] rdy, rdy2;
   logic [0:0] gid, gid2;
   logic       bsy, bsy2;
   logic [7:0] dat, dat2;
   logic       snd, snd2;
   logic       par, par2;
   logic       tmo, tmo2;

   int checks = 0;
   int errors = 0;

   item_t      sb[$];
   logic [0:0] glog[$];
   item_t      it;
   int  mptr = 0;
   int  pcnt = 0;
   int  mode = 0;
   int  alen = 3;
   int  gapc = 0;
   int  tcnt = 0;
   int  nacc = 0;
   bit  send_due = 0;
   bit  pending = 0;
   logic [8:0] held = '0;

   always #5 clk = ~clk;

   uart_tx_sched #(
      .NREQ             (NREQ),
      .PARITY_ODD       (0),
      .GAP_CYCLES       (GAP),
      .TIMEOUT_CYCLES   (TMO)
   ) dut (
      .baud_clk         (clk),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_ready        (rdy),
      .grant_id         (gid),
      .busy             (bsy),
      .piso_data_in     (dat),
      .piso_send        (snd),
      .piso_parity_bit  (par),
      .piso_active_flag (act),
      .piso_done_flag   (done),
      .timeout_err      (tmo)
   );

   uart_tx_sched #(
      .NREQ             (NREQ),
      .PARITY_ODD       (1),
      .GAP_CYCLES       (GAP),
      .TIMEOUT_CYCLES   (TMO)
   ) dut_odd (
      .baud_clk         (clk),
      .reset_n          (reset_n),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_ready        (rdy2),
      .grant_id         (gid2),
      .busy             (bsy2),
      .piso_data_in     (dat2),
      .piso_send        (snd2),
      .piso_parity_bit  (par2),
      .piso_active_flag (act),
      .piso_done_flag   (done),
      .timeout_err      (tmo2)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {2'b00, rdy, gid, bsy, dat, snd, par, tmo,
              rdy2, gid2, bsy2, dat2, snd2, par2, tmo2};
   endfunction

   function automatic logic [NREQ-1:0] arb_f(input logic [NREQ-1:0] v,
                                            input int p);
      logic [NREQ-1:0] g;
      g = '0;
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (p + k) % NREQ;
         if (v[i] && g == '0)
            g[i] = 1'b1;
      end
      return g;
   endfunction

   // Monitor, scoreboard and PISO model, all at the falling edge
   initial forever begin
      logic [NREQ-1:0] er;
      logic            exp_to;
      bit              mbusy;
      int              idx;
      @(negedge clk);
      if (!reset_n) begin
         chk("rst_out", outs(), 0);
         mptr = 0; sb.delete(); send_due = 0; pending = 0;
         gapc = 0; pcnt = 0; tcnt = 0; act = 0; done = 0;
      end else begin
         chk("send", snd, send_due);
         if (send_due) begin
            glog.push_back(gid);
            if (sb.size() == 0) begin
               chk("sb_empty", 0, 1);
            end else begin
               it = sb.pop_front();
               chk("data", dat, it.d);
               chk("par_even", par, it.p);
               chk("par_odd", par2, it.po);
               chk("grant_id", gid, it.id);
               held = {it.d, it.p};
            end
            chk("overlap", pending, 0);
            pending = 1; tcnt = 0; send_due = 0;
         end else if (pending) begin
            tcnt++;
            chk("hold", {dat, par}, held);
         end
         exp_to = 1'b0;
`ifdef UART_TX_TIMEOUT_EN
         exp_to = pending && mode == 2 && tcnt == TMO;
`endif
         chk("timeout", tmo, exp_to);
         if (exp_to) begin
            pending = 0; gapc = 1;
         end else if (gapc > 0) begin
            if (!bsy || gapc > GAP + 3) begin
               chk("gap_len", gapc, GAP + 1);
               gapc = 0;
            end else begin
               gapc++;
            end
         end
         mbusy = send_due || pending || gapc > 0;
         chk("busy", bsy, mbusy);
         if (!mbusy) begin
            er = arb_f(req_valid, mptr);
            chk("ready", rdy, er);
            if (er != '0) begin
               idx = er[1] ? 1 : 0;
               it.d  = req_data[idx*8 +: 8];
               it.p  = ^it.d;
               it.po = ~^it.d;
               it.id = idx[0:0];
               sb.push_back(it);
               nacc++;
               mptr = (idx + 1) % NREQ;
               send_due = 1;
            end
         end else begin
            chk("ready_busy", rdy, 0);
         end
         if (pcnt == 0) begin
            done = 0;
            if (snd && mode != 2)
               pcnt = 1;
         end else begin
            pcnt++;
            if (mode == 1 || pcnt == 2 + alen) begin
               act = 0; done = 1; pcnt = 0;
               pending = 0; gapc = 1;
            end else if (pcnt == 2) begin
               act = 1;
            end
         end
      end
   end

   task automatic wait_acc(input int k);
      int tgt;
      int t;
      tgt = nacc + k;
      t = 0;
      while (nacc < tgt && t < 400) begin
         @(posedge clk); #2;
         t++;
      end
      if (nacc < tgt)
         chk("acc_wait", nacc, tgt);
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((send_due || pending || gapc > 0) && t < 400) begin
         @(posedge clk); #2;
         t++;
      end
      if (send_due || pending || gapc > 0)
         chk("idle_wait", 1, 0);
   endtask

   // Stimulus
   initial begin
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;

      glog.delete();
      req_data  = {8'h5A, 8'h4A};
      req_valid = 2'b11;
      wait_acc(4);
      req_valid = 2'b00;
      wait_idle();
      chk("rot_cnt", glog.size(), 4);
      for (int i = 0; i < glog.size() && i < 4; i++)
         chk("rotation", glog[i], i % 2);

      req_valid = 2'b01;
      wait_acc(1);
      req_valid = 2'b00;
      wait_idle();

      mode = 1;
      req_valid = 2'b10;
      wait_acc(1);
      req_valid = 2'b00;
      wait_idle();
      mode = 0;

      alen = 20;
      req_valid = 2'b01;
      wait_acc(1);
      repeat (4) @(posedge clk);
      #2 reset_n = 1'b0;
      #1 chk("rst_async", outs(), 0);
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      alen = 3;
      req_valid = 2'b11;
      wait_acc(1);
      req_valid = 2'b00;
      wait_idle();

      for (int i = 0; i < 6; i++) begin
         req_data  = 16'($urandom);
         req_valid = 2'($urandom_range(1, 3));
         alen      = $urandom_range(1, 4);
         wait_acc(1);
         req_valid = 2'b00;
         wait_idle();
      end

`ifdef UART_TX_TIMEOUT_EN
      mode = 2;
      req_data  = {8'h5A, 8'h4A};
      req_valid = 2'b11;
      wait_acc(2);
      req_valid = 2'b00;
      wait_idle();
      mode = 0;
`endif

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
